instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 tb/tb_instr_fetch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_entry_t : one prefetch FIFO entry, an instruction word and its PC.
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0).
package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch_entry_t, no bypass.
//   clk_i, rst_i : clock, synchronous active-high reset (pointers only)
//   push_i/data_i: write an entry (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : discard all entries
//   data_o       : head entry (meaningful only when !empty_o)
//   count_o      : number of stored entries
//   full_o/empty_o: occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  fetch_entry_t                  data_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output fetch_entry_t                  data_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  fetch_entry_t mem [FIFO_DEPTH];

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count_o = wr_ptr - rd_ptr;
  assign data_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_i  && !empty_o) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding ctrl_unit.
//   Owns the fetch PC, issues word requests over req/gnt/rvalid, buffers
//   returned words with their PCs in fetch_fifo, and presents the head under
//   valid/ready. A redirect flushes the FIFO and drops in-flight responses.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   imem_req_o, imem_addr_o     : request and its word address
//   imem_gnt_i                  : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i : in-order response
//   instr_o, pc_o, pc_four_o    : head instruction, its PC, PC+4
//   instr_valid_o, instr_ready_i: head handshake with the consumer
//   redirect_i, redirect_pc_i   : taken branch/jump and its target
// Optional feature macro FETCH_PERF_EN adds fetch_cnt_o (pops) and
// stall_cnt_o (cycles out of reset with no valid instruction).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_four_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  logic [31:0]   fpc;            // next fetch address
  logic [31:0]   resp_pc;        // PC of the next response that will be kept
  logic [31:0]   hold_pc;        // redirect target parked behind a stalled request
  logic          hold_redirect;  // pending request is stale; retarget after its grant
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;

  logic          pop;
  logic          gnt;
  logic          push;
  logic          req_waiting;
  logic [31:0]   target;
  logic [CW-1:0] occupancy;

  assign pop         = instr_valid_o & instr_ready_i;
  assign target      = redirect_pc_i & 32'hFFFF_FFFC;
  // Words already held or promised, less the one leaving this cycle.
  assign occupancy   = {1'b0, count} + outstanding - CW'(pop);
  assign imem_req_o  = !rst_i && (occupancy < CW'(FIFO_DEPTH));
  assign imem_addr_o = fpc;
  assign gnt         = imem_req_o & imem_gnt_i;
  assign req_waiting = imem_req_o & ~imem_gnt_i;
  assign push        = imem_rvalid_i && (discard == '0) && !redirect_i && !fifo_full;

  assign push_entry.instr = imem_rdata_i;
  assign push_entry.pc    = resp_pc;

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop && !redirect_i),
    .flush_i (redirect_i),
    .data_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = instr_valid_o ? head.instr : 32'h0;
  assign pc_o          = instr_valid_o ? head.pc    : 32'h0;
  assign pc_four_o     = pc_o + 32'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc           <= RESET_PC;
      resp_pc       <= RESET_PC;
      hold_redirect <= 1'b0;
      outstanding   <= '0;
      discard       <= '0;
    end else begin
      outstanding <= outstanding + CW'(gnt) - CW'(imem_rvalid_i);
      if (redirect_i) begin
        // Everything in flight after this edge belongs to the old path.
        resp_pc <= target;
        discard <= outstanding + CW'(gnt) - CW'(imem_rvalid_i);
        if (req_waiting) begin
          // Keep the stalled request stable; it becomes a discard when granted.
          hold_redirect <= 1'b1;
        end else begin
          hold_redirect <= 1'b0;
          fpc           <= target;
        end
      end else begin
        if (push) resp_pc <= resp_pc + 32'd4;
        discard <= discard - CW'(imem_rvalid_i && (discard != '0))
                           + CW'(gnt && hold_redirect);
        if (gnt) begin
          fpc           <= hold_redirect ? hold_pc : fpc + 32'd4;
          hold_redirect <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (redirect_i && req_waiting) hold_pc <= target;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o <= 32'h0;
      stall_cnt_o <= 32'h0;
    end else begin
      if (pop)            fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (!instr_valid_o) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with an in-order memory model
// of configurable latency and a transaction-level reference model of the
// expected fetch-address and delivered-instruction streams.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_four;
  logic        instr_valid;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        gnt_en;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_en;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (mem_rvalid),
    .imem_rdata_i  (mem_rdata),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_four_o     (pc_four),
    .instr_valid_o (instr_valid),
    .instr_ready_i (ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o   (fetch_cnt),
    .stall_cnt_o   (stall_cnt)
`endif
  );

  // Instruction word stored at an address; ties each word to its PC.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // In-order memory: each granted address answers lat cycles after its grant.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;
  mem_req_t mq[$];
  int       lat = 1;
  int       mcyc = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'h0;
      mcyc       <= 0;
    end else begin
      if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: mcyc + lat});
      if (mq.size() > 0 && mq[0].due <= mcyc + 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= word_at(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mem_rvalid <= 1'b0;
      end
      mcyc <= mcyc + 1;
    end
  end

  // Reference model: the fetch address sequence advances by 4 per grant and
  // restarts at each redirect target; every grant made before a redirect
  // (including a request stalled across it) is never delivered; delivered
  // instructions appear in grant order.
  always @(negedge clk) begin : model
    static logic [31:0] live[$];
    static logic [31:0] exp_addr  = 32'h0;
    static logic        dead_pend = 1'b0;
    static logic        prev_pend = 1'b0;
    static logic [31:0] prev_addr = 32'h0;
    logic [31:0] e;
    if (rst) begin
      live.delete();
      exp_addr  = 32'h0;
      dead_pend = 1'b0;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("req_held", {31'b0, imem_req}, 32'd1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (instr_valid && ready && !redirect) begin
        if (live.size() == 0) begin
          check("pop_without_expected_word", 32'd1, 32'd0);
        end else begin
          e = live.pop_front();
          check("pop_pc", pc_o, e);
          check("pop_instr", instr_o, word_at(e));
          check("pop_pc_four", pc_four, e + 32'd4);
        end
      end
      if (imem_req && imem_gnt) begin
        if (dead_pend) begin
          dead_pend = 1'b0;
        end else begin
          check("req_addr", imem_addr, exp_addr);
          live.push_back(exp_addr);
          exp_addr = exp_addr + 32'd4;
        end
      end
      if (redirect) begin
        live.delete();
        if (imem_req && !imem_gnt) dead_pend = 1'b1;
        exp_addr = redirect_pc & 32'hFFFF_FFFC;
      end
      prev_pend = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
  end

  task automatic do_reset(input int l, input logic rdy);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    redirect = 1'b0;
    lat      = l;
    ready    = rdy;
    gnt_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    check(name, {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    int          g;
    logic        found;
    logic [31:0] a0;

    rst = 1'b1; ready = 1'b1; gnt_en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pc_four", pc_four, 32'h4);

    // Reset release with zero-wait memory.
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("valid_c1", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    check("valid_c2", {31'b0, instr_valid}, 32'd1);
    check("pc_c2", pc_o, 32'h0);
    check("pc_four_c2", pc_four, 32'h4);
    @(negedge clk);
    check("pc_c3", pc_o, 32'h4);
    @(negedge clk);
    check("pc_c4", pc_o, 32'h8);
    repeat (6) @(negedge clk);

    // Consumer stalled: only FIFO_DEPTH words may be requested.
    do_reset(1, 1'b0);
    g = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) g++;
    end
    check("stall_grants", g, 32'd2);
    check("stall_valid", {31'b0, instr_valid}, 32'd1);
    check("stall_pc", pc_o, 32'h0);
    check("stall_instr", instr_o, word_at(32'h0));
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    check("resume_pc0", pc_o, 32'h0);
    @(negedge clk);
    check("resume_pc1", pc_o, 32'h4);
    @(negedge clk);
    check("resume_pc2", pc_o, 32'h8);
    repeat (5) @(negedge clk);

    // Redirect with two responses in flight (two-cycle memory).
    do_reset(2, 1'b1);
    repeat (6) @(posedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mq.size() + int'(mem_rvalid) == 2) found = 1'b1;
    end
    check("two_in_flight", {31'b0, found}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(posedge clk);
    #1 redirect = 1'b0;
    wait_valid("redir_valid");
    check("redir_pc", pc_o, 32'h100);
    check("redir_pc_four", pc_four, 32'h104);
    repeat (6) @(negedge clk);

    // Grant withheld for three cycles with a redirect in the second.
    do_reset(1, 1'b1);
    repeat (5) @(posedge clk);
    #1 gnt_en = 1'b0;
    @(negedge clk);
    check("hold_req_c0", {31'b0, imem_req}, 32'd1);
    a0 = imem_addr;
    @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    check("hold_req_c2", {31'b0, imem_req}, 32'd1);
    check("hold_addr_c2", imem_addr, a0);
    @(posedge clk);
    #1 gnt_en = 1'b1;
    wait_valid("hold_valid");
    check("hold_target_pc", pc_o, 32'h200);

    // Address wrap at the top of the address space.
    @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 redirect = 1'b0;
    wait_valid("wrap_valid");
    check("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    check("wrap_pc_four_top", pc_four, 32'h0);
    @(negedge clk);
    check("wrap_pc_zero", pc_o, 32'h0);
    check("wrap_pc_four_zero", pc_four, 32'h4);
    repeat (4) @(negedge clk);

`ifdef FETCH_PERF_EN
    // Three empty cycles, then five pops.
    do_reset(1, 1'b1);
    gnt_en = 1'b0;
    @(posedge clk);
    #1 gnt_en = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("perf_fetch_cnt", fetch_cnt, 32'd5);
    check("perf_stall_cnt", stall_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
